// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage feeding predecode.
//   Owns the fetch PC, issues at most one instruction-bus request at a time,
//   buffers returned words with their PCs in a small FIFO and presents the
//   head {pc, instr} to predecode under valid/ready. Redirects flush the FIFO
//   and discard any stale in-flight fetch.
//
// Parameters:
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  output buffer entries (2..8)
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ireq_valid / ireq_addr     bus request (held stable until iresp_addr_ok)
//   iresp_addr_ok              bus accepted the request
//   iresp_data_ok / iresp_data bus returns the instruction word
//   redirect_valid / redirect_pc   fetch redirect (flushes buffered work)
//   out_valid / out_ready      head-entry handshake toward predecode
//   out_pc / out_instr         head entry contents
//   out_adel                   head entry is a misaligned-fetch exception
//
// Optional feature macro: FETCH_ADEL_EN
//   Defined: a misaligned fetch PC produces an exception entry instead of a
//   bus request and fetch halts until the next redirect.
//   Undefined: out_adel is 0 and misaligned PCs go to the bus unchanged.

module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_adel
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_redir_pc;
  logic        r_drop;
  logic        r_pend_redir;

  logic [31:0]      r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]      r_fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic        w_space;
  logic        w_ireq_valid;
  logic        w_fire;
  logic        w_adel_push;
  logic        w_data_push;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_push_pc;
  logic [31:0] w_push_instr;

  // Circular pointer advance that also handles non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Only REQ issues; with nothing outstanding there, credit reduces to count < depth.
  assign w_space = (r_count < CNT_W'(FIFO_DEPTH));

`ifdef FETCH_ADEL_EN
  logic             r_halt;
  logic             r_fifo_adel [FIFO_DEPTH];
  logic             w_misalign;

  assign w_misalign   = (r_fetch_pc[1:0] != 2'b00);
  assign w_ireq_valid = !reset && (r_state == S_REQ) && w_space && !w_misalign && !r_halt;
  // Redirect in the same cycle wins over the exception entry.
  assign w_adel_push  = (r_state == S_REQ) && w_space && w_misalign && !r_halt && !redirect_valid;
  assign out_adel     = r_fifo_adel[r_head];
`else
  assign w_ireq_valid = !reset && (r_state == S_REQ) && w_space;
  assign w_adel_push  = 1'b0;
  assign out_adel     = 1'b0;
`endif

  assign w_fire       = w_ireq_valid && iresp_addr_ok;
  assign w_data_push  = (r_state == S_WAIT) && iresp_data_ok && !r_drop && !redirect_valid;
  assign w_push       = w_data_push || w_adel_push;
  assign w_pop        = (r_count != '0) && out_ready && !redirect_valid;
  assign w_push_pc    = w_adel_push ? r_fetch_pc : r_req_pc;
  assign w_push_instr = w_adel_push ? 32'h0 : iresp_data;

  assign ireq_valid = w_ireq_valid;
  assign ireq_addr  = r_fetch_pc;
  assign out_valid  = (r_count != '0);
  assign out_pc     = r_fifo_pc[r_head];
  assign out_instr  = r_fifo_instr[r_head];

  // Output FIFO; a redirect flushes it and overrides any same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= '0;
`ifdef FETCH_ADEL_EN
        r_fifo_adel[i]  <= 1'b0;
`endif
      end
    end else if (redirect_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_tail]    <= w_push_pc;
        r_fifo_instr[r_tail] <= w_push_instr;
`ifdef FETCH_ADEL_EN
        r_fifo_adel[r_tail]  <= w_adel_push;
`endif
        r_tail <= ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= ptr_inc(r_head);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Fetch FSM: PC ownership, request/response tracking and redirect handling.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_REQ;
      r_fetch_pc   <= RESET_PC;
      r_req_pc     <= '0;
      r_redir_pc   <= '0;
      r_drop       <= 1'b0;
      r_pend_redir <= 1'b0;
`ifdef FETCH_ADEL_EN
      r_halt       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_fire) begin
            r_req_pc     <= r_fetch_pc;
            r_state      <= S_WAIT;
            r_pend_redir <= 1'b0;
            // A redirect seen while the request was held makes its data stale.
            if (redirect_valid) begin
              r_drop     <= 1'b1;
              r_redir_pc <= redirect_pc;
            end else if (r_pend_redir) begin
              r_drop     <= 1'b1;
            end
          end else if (redirect_valid) begin
            if (w_ireq_valid) begin
              // Request already presented: keep addr stable, defer the redirect.
              r_pend_redir <= 1'b1;
              r_redir_pc   <= redirect_pc;
            end else begin
              r_fetch_pc <= redirect_pc;
`ifdef FETCH_ADEL_EN
              r_halt     <= 1'b0;
`endif
            end
          end
`ifdef FETCH_ADEL_EN
          else if (w_adel_push) begin
            r_halt <= 1'b1;
          end
`endif
        end
        S_WAIT: begin
          if (iresp_data_ok) begin
            r_state <= S_REQ;
            r_drop  <= 1'b0;
            if (redirect_valid) begin
              r_fetch_pc <= redirect_pc;
            end else if (r_drop) begin
              r_fetch_pc <= r_redir_pc;
            end else begin
              r_fetch_pc <= r_req_pc + 32'd4;
            end
          end else if (redirect_valid) begin
            r_drop     <= 1'b1;
            r_redir_pc <= redirect_pc;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: simple bus responder plus per-scenario tasks.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_adel;

  int vectors = 0;
  int errors  = 0;
  int cyc, first_ok, first_valid;

  logic        bus_auto, bus_data_en, bus_pending;
  logic [31:0] bus_addr;
  logic [31:0] iss[$];
  logic [31:0] lg_pc[$];
  logic [31:0] lg_instr[$];
  logic        lg_adel[$];

  fetch_stage #(.RESET_PC(32'hBFC0_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_adel(out_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: return 32'h2408_0001;
      32'hBFC0_0004: return 32'h2409_0002;
      default:       return ~a;
    endcase
  endfunction

  // One clock: drive bus response, log issues and pops, advance the edge.
  task automatic tick();
    logic took;
    logic [31:0] a;
    iresp_addr_ok = bus_auto && ireq_valid;
    iresp_data_ok = bus_pending && bus_data_en;
    iresp_data    = iresp_data_ok ? mem_word(bus_addr) : 32'hDEAD_BEEF;
    took = ireq_valid && iresp_addr_ok;
    a    = ireq_addr;
    if (took) begin
      iss.push_back(a);
      if (first_ok < 0) first_ok = cyc;
    end
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (out_valid && out_ready && !redirect_valid) begin
      lg_pc.push_back(out_pc);
      lg_instr.push_back(out_instr);
      lg_adel.push_back(out_adel);
    end
    @(posedge clk);
    #1;
    if (iresp_data_ok) bus_pending = 1'b0;
    if (took) begin
      bus_pending = 1'b1;
      bus_addr    = a;
    end
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b0;
    cyc++;
  endtask

  task automatic run_until_log(input int n, input int bound, input string tag);
    int k = 0;
    while (lg_pc.size() < n && k < bound) begin
      tick();
      k++;
    end
    vectors++;
    if (lg_pc.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d entries, need %0d", tag, lg_pc.size(), n);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b0;
    bus_auto = 1'b0; bus_data_en = 1'b1; bus_pending = 1'b0; bus_addr = '0;
    iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    iss.delete(); lg_pc.delete(); lg_instr.delete(); lg_adel.delete();
    first_ok = -1; first_valid = -1; cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    bus_auto = 1'b0; bus_data_en = 1'b1; bus_pending = 1'b0; bus_addr = '0;
    iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = '0;
    first_ok = -1; first_valid = -1; cyc = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++; if (ireq_valid !== 1'b0) begin errors++; $display("FAIL rst_ireq_valid: got %b want 0", ireq_valid); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_out_pc: got %h want 0", out_pc); end
    vectors++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_out_instr: got %h want 0", out_instr); end
    vectors++; if (out_adel !== 1'b0) begin errors++; $display("FAIL rst_out_adel: got %b want 0", out_adel); end
    reset = 1'b0;
    #1;
    vectors++; if (ireq_valid !== 1'b1) begin errors++; $display("FAIL rst_first_req: got %b want 1", ireq_valid); end
    vectors++; if (ireq_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL rst_first_addr: got %h want bfc00000", ireq_addr); end
    // Stray data_ok while nothing is outstanding must be ignored.
    bus_pending = 1'b1; bus_addr = 32'h1234_5670;
    tick();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stray_data_valid: got %b want 0", out_valid); end
    vectors++; if (ireq_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL stray_data_addr: got %h want bfc00000", ireq_addr); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    out_ready = 1'b1; bus_auto = 1'b1;
    run_until_log(2, 20, "zw");
    vectors++; if (lg_pc[0] !== 32'hBFC0_0000) begin errors++; $display("FAIL zw_pc0: got %h want bfc00000", lg_pc[0]); end
    vectors++; if (lg_instr[0] !== 32'h2408_0001) begin errors++; $display("FAIL zw_instr0: got %h want 24080001", lg_instr[0]); end
    vectors++; if (lg_pc[1] !== 32'hBFC0_0004) begin errors++; $display("FAIL zw_pc1: got %h want bfc00004", lg_pc[1]); end
    vectors++; if (lg_instr[1] !== 32'h2409_0002) begin errors++; $display("FAIL zw_instr1: got %h want 24090002", lg_instr[1]); end
    vectors++; if (first_valid - first_ok !== 2) begin errors++; $display("FAIL zw_latency: got %0d want 2", first_valid - first_ok); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; bus_auto = 1'b1;
    repeat (10) tick();
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    vectors++; if (out_pc !== 32'hBFC0_0000) begin errors++; $display("FAIL bp_head_pc: got %h want bfc00000", out_pc); end
    vectors++; if (out_instr !== 32'h2408_0001) begin errors++; $display("FAIL bp_head_instr: got %h want 24080001", out_instr); end
    vectors++; if (ireq_valid !== 1'b0) begin errors++; $display("FAIL bp_full_noreq: got %b want 0", ireq_valid); end
    vectors++; if (iss.size() !== 2) begin errors++; $display("FAIL bp_issued: got %0d want 2", iss.size()); end
    out_ready = 1'b1;
    run_until_log(4, 40, "bp");
    vectors++; if (lg_pc[0] !== 32'hBFC0_0000) begin errors++; $display("FAIL bp_pc0: got %h want bfc00000", lg_pc[0]); end
    vectors++; if (lg_pc[1] !== 32'hBFC0_0004) begin errors++; $display("FAIL bp_pc1: got %h want bfc00004", lg_pc[1]); end
    vectors++; if (lg_pc[2] !== 32'hBFC0_0008) begin errors++; $display("FAIL bp_pc2: got %h want bfc00008", lg_pc[2]); end
    vectors++; if (lg_instr[2] !== 32'h403F_FFF7) begin errors++; $display("FAIL bp_instr2: got %h want 403ffff7", lg_instr[2]); end
    vectors++; if (lg_pc[3] !== 32'hBFC0_000C) begin errors++; $display("FAIL bp_pc3: got %h want bfc0000c", lg_pc[3]); end
    vectors++; if (lg_instr[3] !== 32'h403F_FFF3) begin errors++; $display("FAIL bp_instr3: got %h want 403ffff3", lg_instr[3]); end
  endtask

  task automatic test_redirect_held();
    do_reset();
    out_ready = 1'b1; bus_auto = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    vectors++; if (ireq_valid !== 1'b1) begin errors++; $display("FAIL held_valid: got %b want 1", ireq_valid); end
    vectors++; if (ireq_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL held_addr1: got %h want bfc00000", ireq_addr); end
    tick();
    vectors++; if (ireq_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL held_addr2: got %h want bfc00000", ireq_addr); end
    bus_auto = 1'b1;
    run_until_log(1, 20, "held");
    vectors++; if (iss[0] !== 32'hBFC0_0000) begin errors++; $display("FAIL held_iss0: got %h want bfc00000", iss[0]); end
    vectors++; if (iss[1] !== 32'h8000_0100) begin errors++; $display("FAIL held_iss1: got %h want 80000100", iss[1]); end
    vectors++; if (lg_pc[0] !== 32'h8000_0100) begin errors++; $display("FAIL held_pc0: got %h want 80000100", lg_pc[0]); end
    vectors++; if (lg_instr[0] !== 32'h7FFF_FEFF) begin errors++; $display("FAIL held_instr0: got %h want 7ffffeff", lg_instr[0]); end
  endtask

  task automatic test_redirect_data_ok();
    do_reset();
    out_ready = 1'b0; bus_auto = 1'b1;
    repeat (3) tick();
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rdo_pre_valid: got %b want 1", out_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rdo_flush: got %b want 0", out_valid); end
    out_ready = 1'b1;
    run_until_log(1, 20, "rdo");
    vectors++; if (iss[2] !== 32'h8000_0200) begin errors++; $display("FAIL rdo_iss2: got %h want 80000200", iss[2]); end
    vectors++; if (lg_pc[0] !== 32'h8000_0200) begin errors++; $display("FAIL rdo_pc0: got %h want 80000200", lg_pc[0]); end
    vectors++; if (lg_instr[0] !== 32'h7FFF_FDFF) begin errors++; $display("FAIL rdo_instr0: got %h want 7ffffdff", lg_instr[0]); end
  endtask

  task automatic test_two_redirects();
    do_reset();
    out_ready = 1'b1; bus_auto = 1'b1; bus_data_en = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect_pc = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0; bus_data_en = 1'b1;
    run_until_log(2, 30, "two");
    vectors++; if (iss[1] !== 32'h8000_0200) begin errors++; $display("FAIL two_iss1: got %h want 80000200", iss[1]); end
    vectors++; if (lg_pc[0] !== 32'h8000_0200) begin errors++; $display("FAIL two_pc0: got %h want 80000200", lg_pc[0]); end
    vectors++; if (lg_instr[0] !== 32'h7FFF_FDFF) begin errors++; $display("FAIL two_instr0: got %h want 7ffffdff", lg_instr[0]); end
    vectors++; if (lg_pc[1] !== 32'h8000_0204) begin errors++; $display("FAIL two_pc1: got %h want 80000204", lg_pc[1]); end
    vectors++; if (lg_instr[1] !== 32'h7FFF_FDFB) begin errors++; $display("FAIL two_instr1: got %h want 7ffffdfb", lg_instr[1]); end
  endtask

  // Redirect coincides with addr_ok, then the PC wraps past 2^32.
  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1; bus_auto = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    run_until_log(2, 30, "wrap");
    vectors++; if (lg_pc[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0: got %h want fffffffc", lg_pc[0]); end
    vectors++; if (lg_instr[0] !== 32'h0000_0003) begin errors++; $display("FAIL wrap_instr0: got %h want 00000003", lg_instr[0]); end
    vectors++; if (lg_pc[1] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc1: got %h want 00000000", lg_pc[1]); end
    vectors++; if (lg_instr[1] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_instr1: got %h want ffffffff", lg_instr[1]); end
  endtask

  task automatic test_misaligned();
    do_reset();
    out_ready = 1'b1; bus_auto = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    run_until_log(1, 20, "mis");
    vectors++; if (lg_pc[0] !== 32'h8000_0102) begin errors++; $display("FAIL mis_pc0: got %h want 80000102", lg_pc[0]); end
`ifdef FETCH_ADEL_EN
    vectors++; if (lg_instr[0] !== 32'h0) begin errors++; $display("FAIL mis_instr0: got %h want 0", lg_instr[0]); end
    vectors++; if (lg_adel[0] !== 1'b1) begin errors++; $display("FAIL mis_adel0: got %b want 1", lg_adel[0]); end
    repeat (5) tick();
    vectors++; if (iss.size() !== 1) begin errors++; $display("FAIL mis_no_bus: got %0d issues want 1", iss.size()); end
    vectors++; if (ireq_valid !== 1'b0) begin errors++; $display("FAIL mis_halted: got %b want 0", ireq_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    vectors++; if (ireq_valid !== 1'b1) begin errors++; $display("FAIL mis_resume_valid: got %b want 1", ireq_valid); end
    vectors++; if (ireq_addr !== 32'h8000_0300) begin errors++; $display("FAIL mis_resume_addr: got %h want 80000300", ireq_addr); end
`else
    vectors++; if (lg_instr[0] !== 32'h7FFF_FEFD) begin errors++; $display("FAIL mis_instr0: got %h want 7ffffefd", lg_instr[0]); end
    vectors++; if (lg_adel[0] !== 1'b0) begin errors++; $display("FAIL mis_adel0: got %b want 0", lg_adel[0]); end
    vectors++; if (iss[1] !== 32'h8000_0102) begin errors++; $display("FAIL mis_iss1: got %h want 80000102", iss[1]); end
`endif
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_redirect_held();
    test_redirect_data_ok();
    test_two_redirects();
    test_wrap();
    test_misaligned();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
